// File: rtl/id_stage.sv
// Decode stage of the LA32R 5-stage pipeline: latches fetch output, reads the
// register file, detects RAW hazards against EX/MEM, resolves branches and builds the EX bundle.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         IDsignal_valid,
  input  logic [63:0]  ID_signal,
  output logic         ID_allowin,
  output logic [32:0]  br_signal,
  input  logic         EX_allowin,
  output logic         EXsignal_valid,
  output logic [147:0] EX_signal,
  input  logic [5:0]   EX_dest_signal,
  input  logic [5:0]   MEM_dest_signal,
  input  logic [37:0]  WB_rf_signal
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned NREG    = 32;
  localparam int unsigned ALUOP_W = 12;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               load_op;
    logic               mem_we;
    logic               rf_we;
    logic [RA_W-1:0]    dest;
    logic [XLEN-1:0]    alu_src1;
    logic [XLEN-1:0]    alu_src2;
    logic [XLEN-1:0]    rkd_value;
    logic [XLEN-1:0]    pc;
  } ex_bundle_t;

  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rf_q [NREG];

  logic            id_allowin_c, id_readygo_c, hazard_c;
  logic            wb_we;
  logic [RA_W-1:0] wb_waddr;
  logic [XLEN-1:0] wb_wdata;

  assign wb_we    = WB_rf_signal[37];
  assign wb_waddr = WB_rf_signal[36:32];
  assign wb_wdata = WB_rf_signal[31:0];

  // Pipeline register between fetch and decode
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      inst_q     <= '0;
      pc_q       <= RESET_PC;
    end else begin
      id_valid_q <= id_valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    id_valid_d = id_valid_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    if (id_allowin_c) begin
      id_valid_d = IDsignal_valid;
      inst_d     = ID_signal[63:32];
      pc_d       = ID_signal[31:0];
    end
  end

  // Register file write port; contents deliberately not reset, r0 never written
  always_ff @(posedge clk) begin
    if (wb_we && (wb_waddr != '0)) begin
      rf_q[wb_waddr] <= wb_wdata;
    end
  end

  logic [RA_W-1:0] rj, rk, rd;
  logic [16:0]     op17;
  logic [9:0]      op10;
  logic [5:0]      op6;
  logic [6:0]      op7;

  assign rd   = inst_q[4:0];
  assign rj   = inst_q[9:5];
  assign rk   = inst_q[14:10];
  assign op17 = inst_q[31:15];
  assign op10 = inst_q[31:22];
  assign op6  = inst_q[31:26];
  assign op7  = inst_q[31:25];

  logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor;
  logic i_slli, i_srli, i_srai, i_addi, i_ld, i_st;
  logic i_jirl, i_b, i_bl, i_beq, i_bne, i_lu12i;

  assign i_add   = (op17 == 17'h00020);
  assign i_sub   = (op17 == 17'h00022);
  assign i_slt   = (op17 == 17'h00024);
  assign i_sltu  = (op17 == 17'h00025);
  assign i_nor   = (op17 == 17'h00028);
  assign i_and   = (op17 == 17'h00029);
  assign i_or    = (op17 == 17'h0002a);
  assign i_xor   = (op17 == 17'h0002b);
  assign i_slli  = (op17 == 17'h00081);
  assign i_srli  = (op17 == 17'h00089);
  assign i_srai  = (op17 == 17'h00091);
  assign i_addi  = (op10 == 10'h00a);
  assign i_ld    = (op10 == 10'h0a2);
  assign i_st    = (op10 == 10'h0a6);
  assign i_jirl  = (op6 == 6'h13);
  assign i_b     = (op6 == 6'h14);
  assign i_bl    = (op6 == 6'h15);
  assign i_beq   = (op6 == 6'h16);
  assign i_bne   = (op6 == 6'h17);
  assign i_lu12i = (op7 == 7'h0a);

  logic is_3r, is_shift, is_imm12, is_link, use_rj, use_rd;

  assign is_3r    = i_add | i_sub | i_slt | i_sltu | i_nor | i_and | i_or | i_xor;
  assign is_shift = i_slli | i_srli | i_srai;
  assign is_imm12 = i_addi | i_ld | i_st;
  assign is_link  = i_bl | i_jirl;
  assign use_rj   = is_3r | is_shift | is_imm12 | i_jirl | i_beq | i_bne;
  assign use_rd   = i_st | i_beq | i_bne;

  // Two async read ports with write-through from WB
  logic [RA_W-1:0] raddr2;
  logic [XLEN-1:0] rj_val, r2_val;

  assign raddr2 = use_rd ? rd : rk;
  assign rj_val = (rj == '0) ? '0 : (wb_we && (wb_waddr == rj)) ? wb_wdata : rf_q[rj];
  assign r2_val = (raddr2 == '0) ? '0 : (wb_we && (wb_waddr == raddr2)) ? wb_wdata : rf_q[raddr2];

  function automatic logic src_hit(input logic used, input logic [RA_W-1:0] src,
                                   input logic [5:0] ex_d, input logic [5:0] mem_d);
    return used && (src != '0) &&
           ((ex_d[5] && (ex_d[4:0] == src)) || (mem_d[5] && (mem_d[4:0] == src)));
  endfunction

  assign hazard_c = src_hit(use_rj, rj, EX_dest_signal, MEM_dest_signal) |
                    src_hit(is_3r,  rk, EX_dest_signal, MEM_dest_signal) |
                    src_hit(use_rd, rd, EX_dest_signal, MEM_dest_signal);

  assign id_readygo_c   = ~hazard_c;
  assign id_allowin_c   = ~id_valid_q | (id_readygo_c & EX_allowin);
  assign ID_allowin     = id_allowin_c;
  assign EXsignal_valid = id_valid_q & id_readygo_c;

  // EX bundle assembly
  ex_bundle_t bundle_c;

  always_comb begin
    bundle_c            = '0;
    bundle_c.alu_op[0]  = i_add | is_imm12 | is_link;
    bundle_c.alu_op[1]  = i_sub;
    bundle_c.alu_op[2]  = i_slt;
    bundle_c.alu_op[3]  = i_sltu;
    bundle_c.alu_op[4]  = i_and;
    bundle_c.alu_op[5]  = i_nor;
    bundle_c.alu_op[6]  = i_or;
    bundle_c.alu_op[7]  = i_xor;
    bundle_c.alu_op[8]  = i_slli;
    bundle_c.alu_op[9]  = i_srli;
    bundle_c.alu_op[10] = i_srai;
    bundle_c.alu_op[11] = i_lu12i;
    bundle_c.load_op    = i_ld;
    bundle_c.mem_we     = i_st;
    bundle_c.rf_we      = is_3r | is_shift | i_addi | i_ld | is_link | i_lu12i;
    bundle_c.dest       = i_bl ? RA_W'(1) : rd;
    bundle_c.alu_src1   = is_link ? pc_q : rj_val;
    if (is_imm12)      bundle_c.alu_src2 = {{20{inst_q[21]}}, inst_q[21:10]};
    else if (is_shift) bundle_c.alu_src2 = {27'b0, inst_q[14:10]};
    else if (i_lu12i)  bundle_c.alu_src2 = {inst_q[24:5], 12'b0};
    else if (is_link)  bundle_c.alu_src2 = XLEN'(4);
    else               bundle_c.alu_src2 = r2_val;
    bundle_c.rkd_value  = r2_val;
    bundle_c.pc         = pc_q;
  end

  assign EX_signal = bundle_c;

  // Branch resolution; target presented only while the branch is leaving ID
  logic [XLEN-1:0] offs16, offs26, br_target;
  logic            br_cond, br_taken;

  assign offs16    = {{14{inst_q[25]}}, inst_q[25:10], 2'b0};
  assign offs26    = {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b0};
  assign br_target = i_jirl ? (rj_val + offs16) :
                     (i_b | i_bl) ? (pc_q + offs26) : (pc_q + offs16);
  assign br_cond   = i_b | i_bl | i_jirl | (i_beq & (rj_val == r2_val)) |
                     (i_bne & (rj_val != r2_val));
  assign br_taken  = id_valid_q & id_readygo_c & EX_allowin & br_cond;
  assign br_signal = br_taken ? {1'b1, br_target} : '0;

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage: a mnemonic-level reference model predicts
// handshake, branch and EX bundle every cycle, plus directed scenarios.
module tb_id_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic         clk = 1'b0;
  logic         reset;
  logic         IDsignal_valid;
  logic [63:0]  ID_signal;
  logic         ID_allowin;
  logic [32:0]  br_signal;
  logic         EX_allowin;
  logic         EXsignal_valid;
  logic [147:0] EX_signal;
  logic [5:0]   EX_dest_signal;
  logic [5:0]   MEM_dest_signal;
  logic [37:0]  WB_rf_signal;

  id_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .IDsignal_valid(IDsignal_valid), .ID_signal(ID_signal),
    .ID_allowin(ID_allowin), .br_signal(br_signal), .EX_allowin(EX_allowin),
    .EXsignal_valid(EXsignal_valid), .EX_signal(EX_signal), .EX_dest_signal(EX_dest_signal),
    .MEM_dest_signal(MEM_dest_signal), .WB_rf_signal(WB_rf_signal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [147:0] got, input logic [147:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: what ID holds and what the register file contains
  bit        mv;
  bit [31:0] minst, mpc;
  bit [31:0] mrf [32];

  typedef enum {K_NOP, K_ADD, K_SUB, K_SLT, K_SLTU, K_NOR, K_AND, K_OR, K_XOR,
                K_SLLI, K_SRLI, K_SRAI, K_ADDI, K_LD, K_ST, K_JIRL, K_B, K_BL,
                K_BEQ, K_BNE, K_LU12I} kind_t;

  typedef struct {
    bit [147:0] bundle;
    bit [147:0] mask;
    bit         hz;
    bit [32:0]  br;
  } exp_t;

  function automatic kind_t classify(input bit [31:0] i);
    bit [16:0] o17 = i[31:15];
    bit [9:0]  o10 = i[31:22];
    bit [5:0]  o6  = i[31:26];
    bit [6:0]  o7  = i[31:25];
    case (o17)
      17'h20: return K_ADD;  17'h22: return K_SUB;  17'h24: return K_SLT;
      17'h25: return K_SLTU; 17'h28: return K_NOR;  17'h29: return K_AND;
      17'h2a: return K_OR;   17'h2b: return K_XOR;  17'h81: return K_SLLI;
      17'h89: return K_SRLI; 17'h91: return K_SRAI;
      default: ;
    endcase
    if (o10 == 10'h00a) return K_ADDI;
    if (o10 == 10'h0a2) return K_LD;
    if (o10 == 10'h0a6) return K_ST;
    case (o6)
      6'h13: return K_JIRL; 6'h14: return K_B; 6'h15: return K_BL;
      6'h16: return K_BEQ;  6'h17: return K_BNE;
      default: ;
    endcase
    if (o7 == 7'h0a) return K_LU12I;
    return K_NOP;
  endfunction

  function automatic int alu_idx(input kind_t k);
    case (k)
      K_SUB: return 1;  K_SLT: return 2;  K_SLTU: return 3; K_AND: return 4;
      K_NOR: return 5;  K_OR: return 6;   K_XOR: return 7;  K_SLLI: return 8;
      K_SRLI: return 9; K_SRAI: return 10; K_LU12I: return 11;
      default: return 0;
    endcase
  endfunction

  function automatic bit [31:0] rv(input bit [4:0] a);
    if (a == 0) return 0;
    if (WB_rf_signal[37] && WB_rf_signal[36:32] == a) return WB_rf_signal[31:0];
    return mrf[a];
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    kind_t k = classify(minst);
    bit [4:0] rd = minst[4:0], rj = minst[9:5], rk = minst[14:10];
    bit [31:0] vj = rv(rj), vk = rv(rk), vd = rv(rd);
    bit signed [11:0] s12 = minst[21:10];
    bit signed [15:0] s16 = minst[25:10];
    bit signed [25:0] s26 = {minst[9:0], minst[25:10]};
    int imm = int'(s12);
    int o16 = int'(s16) * 4;
    int o26 = int'(s26) * 4;
    int opi = -1;
    bit we = 0, ld = 0, st = 0, cond = 0;
    bit [4:0] dest = rd;
    bit [31:0] s1 = vj, s2 = vk, tgt = mpc + 32'(o16);
    bit [4:0] srcs[$];
    e.mask = '1;
    e.mask[63:32] = '0;
    case (k)
      K_ADD, K_SUB, K_SLT, K_SLTU, K_NOR, K_AND, K_OR, K_XOR: begin
        opi = alu_idx(k); we = 1; srcs.push_back(rj); srcs.push_back(rk);
      end
      K_SLLI, K_SRLI, K_SRAI: begin
        opi = alu_idx(k); we = 1; s2 = 32'(rk); srcs.push_back(rj);
      end
      K_ADDI, K_LD, K_ST: begin
        opi = 0; s2 = 32'(imm); srcs.push_back(rj);
        we = (k != K_ST); ld = (k == K_LD); st = (k == K_ST);
        if (k == K_ST) begin srcs.push_back(rd); e.mask[63:32] = '1; end
      end
      K_JIRL: begin
        opi = 0; we = 1; s1 = mpc; s2 = 4; cond = 1; tgt = vj + 32'(o16); srcs.push_back(rj);
      end
      K_B:  begin cond = 1; tgt = mpc + 32'(o26); end
      K_BL: begin opi = 0; we = 1; dest = 1; s1 = mpc; s2 = 4; cond = 1; tgt = mpc + 32'(o26); end
      K_BEQ, K_BNE: begin
        cond = (k == K_BEQ) ? (vj == vd) : (vj != vd);
        srcs.push_back(rj); srcs.push_back(rd); e.mask[95:64] = '0;
      end
      K_LU12I: begin opi = 11; we = 1; s2 = 32'(minst[24:5]) << 12; end
      default: ;
    endcase
    e.hz = 0;
    foreach (srcs[n])
      if (srcs[n] != 0 &&
          ((EX_dest_signal[5] && EX_dest_signal[4:0] == srcs[n]) ||
           (MEM_dest_signal[5] && MEM_dest_signal[4:0] == srcs[n]))) e.hz = 1;
    e.bundle = {(opi >= 0) ? 12'(1 << opi) : 12'h0, ld, st, we, dest, s1, s2, vd, mpc};
    e.br = (mv && !e.hz && EX_allowin && cond) ? {1'b1, tgt} : 33'h0;
    return e;
  endfunction

  task automatic at_neg();
    exp_t e;
    @(negedge clk);
    e = model_eval();
    check("allowin", 148'(ID_allowin), 148'(!mv || (!e.hz && EX_allowin)));
    check("ex_valid", 148'(EXsignal_valid), 148'(mv && !e.hz));
    check("br_signal", 148'(br_signal), 148'(e.br));
    if (mv) check("ex_bundle", EX_signal & e.mask, e.bundle & e.mask);
  endtask

  task automatic advance();
    exp_t e;
    bit allow;
    @(posedge clk);
    e = model_eval();
    allow = !mv || (!e.hz && EX_allowin);
    if (reset) begin
      mv = 0; minst = 0; mpc = RESET_PC;
    end else if (allow) begin
      mv = IDsignal_valid; minst = ID_signal[63:32]; mpc = ID_signal[31:0];
    end
    if (WB_rf_signal[37] && WB_rf_signal[36:32] != 0) mrf[WB_rf_signal[36:32]] = WB_rf_signal[31:0];
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin at_neg(); advance(); end
  endtask

  task automatic feed(input bit [31:0] inst, input bit [31:0] pc);
    IDsignal_valid = 1; ID_signal = {inst, pc};
    tick(1);
    IDsignal_valid = 0;
  endtask

  function automatic bit [31:0] enc_3r(input bit [16:0] op, input bit [4:0] rd, rj, rk);
    return {op, rk, rj, rd};
  endfunction
  function automatic bit [31:0] enc_i12(input bit [9:0] op, input bit [4:0] rd, rj, input bit [11:0] imm);
    return {op, imm, rj, rd};
  endfunction
  function automatic bit [31:0] enc_b16(input bit [5:0] op, input bit [4:0] rj, rd, input bit [15:0] offs);
    return {op, offs, rj, rd};
  endfunction
  function automatic bit [31:0] enc_b26(input bit [5:0] op, input bit [25:0] offs);
    return {op, offs[15:0], offs[25:16]};
  endfunction

  function automatic bit [31:0] rand_inst();
    bit [4:0]  a = 5'($urandom_range(0, 7));
    bit [4:0]  b = 5'($urandom_range(0, 7));
    bit [4:0]  c = 5'($urandom_range(0, 7));
    bit [31:0] r = $urandom;
    bit [16:0] op3;
    case (r[18:16])
      0: op3 = 17'h20; 1: op3 = 17'h22; 2: op3 = 17'h24; 3: op3 = 17'h25;
      4: op3 = 17'h28; 5: op3 = 17'h29; 6: op3 = 17'h2a; default: op3 = 17'h2b;
    endcase
    case ($urandom_range(0, 11))
      1: return enc_3r((r[1:0] == 0) ? 17'h81 : (r[1:0] == 1) ? 17'h89 : 17'h91, a, b, r[6:2]);
      2: return enc_i12(10'h00a, a, b, r[11:0]);
      3: return enc_i12(10'h0a2, a, b, r[11:0]);
      4: return enc_i12(10'h0a6, a, b, r[11:0]);
      5: return enc_b16(6'h13, b, a, r[15:0]);
      6: return enc_b26(6'h14, r[25:0]);
      7: return enc_b26(6'h15, r[25:0]);
      8: return enc_b16(6'h16, b, a, r[15:0]);
      9: return enc_b16(6'h17, b, a, r[15:0]);
      10: return {7'h0a, r[19:0], a};
      11: return r;
      default: return enc_3r(op3, a, b, c);
    endcase
  endfunction

  initial begin
    bit [31:0] pc;
    reset = 1; IDsignal_valid = 0; ID_signal = '0; EX_allowin = 1;
    EX_dest_signal = '0; MEM_dest_signal = '0; WB_rf_signal = '0;
    advance(); advance();
    reset = 0;
    at_neg();
    check("rst_allowin", 148'(ID_allowin), 148'(1));
    check("rst_ex_valid", 148'(EXsignal_valid), 148'(0));
    check("rst_br", 148'(br_signal), 148'(0));
    check("rst_pc", 148'(EX_signal[31:0]), 148'(RESET_PC));
    advance();

    for (int r = 1; r < 32; r++) begin
      WB_rf_signal = {1'b1, 5'(r), $urandom};
      tick(1);
    end
    WB_rf_signal = '0;

    // addi.w r1,r0,5
    feed(32'h02801401, RESET_PC);
    at_neg();
    check("addi_valid", 148'(EXsignal_valid), 148'(1));
    check("addi_aluop", 148'(EX_signal[147:136]), 148'(12'h001));
    check("addi_src2", 148'(EX_signal[95:64]), 148'(5));
    check("addi_dest", 148'(EX_signal[132:128]), 148'(1));
    check("addi_rfwe", 148'(EX_signal[133]), 148'(1));
    advance();

    // WB write-through on the same cycle ID reads the register
    feed(enc_3r(17'h20, 5'd3, 5'd2, 5'd2), 32'h1c000004);
    WB_rf_signal = {1'b1, 5'd2, 32'h1234};
    at_neg();
    check("wt_src1", 148'(EX_signal[127:96]), 148'(32'h1234));
    check("wt_src2", 148'(EX_signal[95:64]), 148'(32'h1234));
    advance();
    WB_rf_signal = '0;

    // RAW stall against EX, next instruction waits at the input
    EX_dest_signal = {1'b1, 5'd3};
    feed(enc_3r(17'h20, 5'd4, 5'd3, 5'd0), 32'h1c000008);
    IDsignal_valid = 1; ID_signal = {enc_i12(10'h00a, 5'd5, 5'd0, 12'd7), 32'h1c00000c};
    repeat (3) begin
      at_neg();
      check("stall_valid", 148'(EXsignal_valid), 148'(0));
      check("stall_allowin", 148'(ID_allowin), 148'(0));
      advance();
    end
    EX_dest_signal = '0;
    at_neg();
    check("unstall_valid", 148'(EXsignal_valid), 148'(1));
    advance();
    IDsignal_valid = 0;
    at_neg();
    check("next_dest", 148'(EX_signal[132:128]), 148'(5));
    advance();

    // beq r1,r1,+8 taken for exactly one cycle
    feed(enc_b16(6'h16, 5'd1, 5'd1, 16'd2), 32'h1c000010);
    at_neg();
    check("beq_br", 148'(br_signal), 148'({1'b1, 32'h1c000018}));
    advance();
    at_neg();
    check("beq_once", 148'(br_signal[32]), 148'(0));
    advance();
    feed(enc_b16(6'h16, 5'd1, 5'd1, 16'd2), 32'h1c000010);
    EX_allowin = 0;
    repeat (3) begin
      at_neg();
      check("beq_held", 148'(br_signal[32]), 148'(0));
      advance();
    end
    EX_allowin = 1;
    at_neg();
    check("beq_release", 148'(br_signal), 148'({1'b1, 32'h1c000018}));
    advance();

    // bl +0x100, then jirl r0,r1,0
    feed(enc_b26(6'h15, 26'h40), 32'h1c000020);
    at_neg();
    check("bl_br", 148'(br_signal), 148'({1'b1, 32'h1c000120}));
    check("bl_dest", 148'(EX_signal[132:128]), 148'(1));
    check("bl_src1", 148'(EX_signal[127:96]), 148'(32'h1c000020));
    check("bl_src2", 148'(EX_signal[95:64]), 148'(4));
    advance();
    WB_rf_signal = {1'b1, 5'd1, 32'h1c000040};
    tick(1);
    WB_rf_signal = '0;
    feed(enc_b16(6'h13, 5'd1, 5'd0, 16'd0), 32'h1c000030);
    at_neg();
    check("jirl_br", 148'(br_signal), 148'({1'b1, 32'h1c000040}));
    advance();

    // EX back-pressure holds the bundle
    feed(enc_i12(10'h00a, 5'd6, 5'd1, 12'hffd), 32'h1c000044);
    EX_allowin = 0;
    repeat (3) begin
      at_neg();
      check("bp_allowin", 148'(ID_allowin), 148'(0));
      check("bp_src2", 148'(EX_signal[95:64]), 148'(32'hfffffffd));
      advance();
    end
    EX_allowin = 1;
    tick(1);

    // undefined opcode behaves as a nop
    feed(32'hffffffff, 32'h1c000048);
    at_neg();
    check("undef_valid", 148'(EXsignal_valid), 148'(1));
    check("undef_rfwe", 148'(EX_signal[133]), 148'(0));
    check("undef_memwe", 148'(EX_signal[134]), 148'(0));
    advance();

    // reset while stalled drops the held instruction
    EX_dest_signal = {1'b1, 5'd3};
    feed(enc_3r(17'h20, 5'd4, 5'd3, 5'd0), 32'h1c00004c);
    reset = 1;
    tick(1);
    reset = 0; EX_dest_signal = '0;
    repeat (2) begin
      at_neg();
      check("rst_stall_valid", 148'(EXsignal_valid), 148'(0));
      check("rst_stall_allowin", 148'(ID_allowin), 148'(1));
      advance();
    end

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pc = $urandom & 32'hfffffffc;
      IDsignal_valid  = ($urandom_range(0, 9) < 7);
      ID_signal       = {rand_inst(), pc};
      EX_allowin      = ($urandom_range(0, 4) != 0);
      EX_dest_signal  = {($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7))};
      MEM_dest_signal = {($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7))};
      WB_rf_signal    = {($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom};
      reset           = ($urandom_range(0, 199) == 0);
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage LA32R teaching pipeline. Sits directly downstream of the fetch stage and upstream of execute.
- Latches {inst, pc} from fetch through a valid/allowin handshake.
- Holds the 32x32 register file; WB writes it.
- Interlocks on RAW hazards against EX/MEM. Resolves branches and returns br_signal to fetch. Emits the decoded bundle to EX.

Parameters:
- RESET_PC, 32'h1c000000, value loaded into the internal pc register on reset. Only debug-visible in EX_signal.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- IDsignal_valid  in  1  fetch holds a valid instruction
- ID_signal  in  64  {inst[63:32], pc[31:0]} from fetch
- ID_allowin  out  1  decode can accept a new instruction this cycle
- br_signal  out  33  {br_taken[32], br_target[31:0]} to fetch
- EX_allowin  in  1  execute can accept
- EXsignal_valid  out  1  bundle to EX is valid
- EX_signal  out  148  {alu_op[147:136], load_op[135], mem_we[134], rf_we[133], dest[132:128], alu_src1[127:96], alu_src2[95:64], rkd_value[63:32], pc[31:0]}
- EX_dest_signal  in  6  {valid&rf_we, dest} of the instruction in EX
- MEM_dest_signal  in  6  {valid&rf_we, dest} of the instruction in MEM
- WB_rf_signal  in  38  {we[37], waddr[36:32], wdata[31:0]}

Behaviour:
- Registers: ID_valid, inst_r, pc_r.
- On reset: ID_valid=0, inst_r=0, pc_r=RESET_PC. Consequently ID_allowin=1, EXsignal_valid=0, br_signal=0.
- ID_readygo = !hazard.
- ID_allowin = !ID_valid | (ID_readygo & EX_allowin).
- When ID_allowin=1: ID_valid<=IDsignal_valid and {inst_r,pc_r}<=ID_signal. Otherwise all three hold.
- EXsignal_valid = ID_valid & ID_readygo. EX_signal is combinational from inst_r/pc_r/regfile.
- Latency: an instruction accepted at edge N is presented to EX during cycle N→N+1.
- Register file:
  - 2 async read ports (rj; rk or rd) and 1 sync write port on clk.
  - Writes to r0 are ignored; reads of r0 return 0.
  - Write-through: a read whose address equals WB waddr while WB we=1 (waddr≠0) returns WB wdata in the same cycle.
  - Contents are not reset.
- Decode (opcode fields, others = nop: rf_we=0, mem_we=0, no branch):
  - 3R, inst[31:15]: add.w 0x20, sub.w 0x22, slt 0x24, sltu 0x25, nor 0x28, and 0x29, or 0x2a, xor 0x2b.
  - Shifts, inst[31:15]: slli.w 0x81, srli.w 0x89, srai.w 0x91.
  - inst[31:22]: addi.w 0x00a, ld.w 0x0a2, st.w 0x0a6.
  - inst[31:26]: jirl 0x13, b 0x14, bl 0x15, beq 0x16, bne 0x17.
  - inst[31:25]: lu12i.w 0x0a.
- alu_op, one-hot, bit0..11: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - addi, ld, st, bl and jirl use add.
- alu_src1: pc for bl/jirl, else rj value.
- alu_src2:
  - sext(si12) for addi/ld/st.
  - zext(ui5) for shifts.
  - si20<<12 for lu12i.
  - 4 for bl/jirl.
  - Else rk value.
- rkd_value = rd value (store data).
- dest: 1 for bl, else rd.
- rf_we=0 for st, b, beq, bne.
- load_op=1 only for ld.w. mem_we=1 only for st.w.
- Hazard: a source register (rj when used; rk for 3R; rd for st/beq/bne) that is ≠0 and equals the dest of EX or MEM with its valid&we bit set. No forwarding; the instruction stalls until the hazard clears.
- Branches:
  - offs16 = sext({inst[25:10],2'b0}). offs26 = sext({inst[9:0],inst[25:10],2'b0}).
  - Targets: beq/bne/b/bl = pc+offs. jirl = rj+offs16.
  - cond: b/bl/jirl always; beq rj==rd; bne rj!=rd.
  - br_taken = ID_valid & ID_readygo & EX_allowin & cond.
  - br_taken is asserted only in the cycle the branch leaves ID. Fetch cancels its in-flight instruction that same cycle.
  - A stalled branch never asserts br_taken.
- Simultaneous events:
  - WB write and hazard check in the same cycle: WB is not part of the hazard check; write-through covers it.
  - Reset mid-stall drops the held instruction; no bundle is issued.

Test Plan:
- Reset 2 cycles → ID_allowin=1, EXsignal_valid=0, br_signal=0. Then feed addi.w r1,r0,5 (0x02801401, pc 0x1c000000) → next cycle EXsignal_valid=1, alu_op=add, alu_src2=5, dest=1, rf_we=1.
- WB writes r2=0x1234 while ID reads r2 for add.w r3,r2,r2 the same cycle → alu_src1=alu_src2=0x1234.
- EX_dest_signal={1,5'd3}, ID holds add.w r4,r3,r0 → EXsignal_valid=0, ID_allowin=0 while asserted. Clearing it → issues the next cycle.
- beq r1,r1,+8 at pc 0x1c000010, EX_allowin=1 → br_signal={1,0x1c000018} for exactly one cycle. Same with EX_allowin=0 → br_taken stays 0 until EX_allowin rises.
- bl +0x100 at pc 0x1c000020 → br_target 0x1c000120, dest=1, alu_src1=0x1c000020, alu_src2=4. jirl r0,r1,0 with r1=0x1c000040 → target 0x1c000040.
- EX_allowin=0 for 3 cycles with a valid instruction → EX_signal stable and ID_allowin=0. An undefined opcode (0xffffffff) → EXsignal_valid=1, rf_we=0, mem_we=0.
